tone_arbiter: RTL and testbench
===============================

Name: tone_arbiter

Overview:
- Shares the single piezo tone generator between three sound sources: two per-track hit-sound requesters and one continuous background-music (BGM) source.
- Sits between the judgement/hit logic (upstream) and the piezo counter (downstream). Drives the generator's enable and frequency limit.
- Latches short-lived hit requests, arbitrates them round-robin, and times each one on the 1 ms tick. Inserts a silent gap between consecutive notes. Falls back to BGM when no hit sound is active.

Parameters:
- SFX_MS, default 100: hit-sound duration in 1 ms ticks.
- GAP_MS, default 5: silent gap after each hit sound, in 1 ms ticks.
- PW, default 32: width of the pitch / counter-limit word.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-low. Asserted when rst==0 on a rising clk edge.
- i_tick  in  1  single-cycle 1 ms strobe.
- i_req  in  2  hit-sound request pulses. [0] is track 1, [1] is track 2.
- i_pitch_t1  in  PW  track-1 pitch, sampled when i_req[0]=1.
- i_pitch_t2  in  PW  track-2 pitch, sampled when i_req[1]=1.
- i_bgm_en  in  1  BGM wants the generator.
- i_bgm_pitch  in  PW  BGM pitch, followed live.
- o_play_en  out  1  tone generator enable.
- o_cnt_limit  out  PW  tone generator limit.
- o_grant  out  2  one-hot owner of the current hit sound; 00 when no hit sound owns the generator.
- o_busy  out  1  high in SFX or GAP.
- o_overwrite  out  1  1-cycle pulse when a pending request is replaced.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; timer=0; pend=00; both pending pitches=0; rr pointer=track 1.
  - All outputs are 0.
- Request capture:
  - Captured on every cycle, in every state.
  - i_req[k]=1 with nonzero pitch: set pend[k] and store the pitch.
  - If pend[k] was already 1 at that time: the stored pitch is overwritten and o_overwrite pulses on the next cycle.
  - i_req[k]=1 with pitch 0: ignored. No pend change, no pulse.
  - A request that arrives in the same cycle a grant clears that requester's pend bit wins: pend stays 1 with the new pitch.
- Round-robin selection:
  - Both pend bits set: grant the track the rr pointer selects.
  - Only one pend bit set: grant that track.
  - After any grant, the rr pointer moves to the other track.
- States:
  - IDLE:
    - If pend!=00: grant. Go to SFX, timer=SFX_MS, clear the granted pend bit, o_grant=one-hot, o_cnt_limit=stored pitch, o_play_en=1. All of these take effect the cycle after the decision edge.
    - Else if i_bgm_en and i_bgm_pitch!=0: go to BGM.
    - Else: outputs 0.
    - Latency: request pulse at edge N → o_play_en=1 at edge N+2. Capture takes one edge, grant the next.
  - BGM:
    - o_play_en=1, o_grant=00. o_cnt_limit is registered from i_bgm_pitch every cycle (1-cycle lag).
    - If pend!=00: preempt. Go to GAP with timer=GAP_MS; the granted SFX follows after the gap.
    - Else if !i_bgm_en or i_bgm_pitch==0: go to IDLE, o_play_en=0.
  - SFX:
    - Outputs held.
    - Timer decrements on each i_tick.
    - When timer==0 on an i_tick: go to GAP, timer=GAP_MS, o_play_en=0, o_grant=00. o_cnt_limit holds its last value.
    - New requests queue. They never preempt the current SFX.
  - GAP:
    - o_play_en=0. Timer decrements on i_tick.
    - On expiry (timer==0 on i_tick), choose in this priority: pend!=00 → SFX (grant as in IDLE); else BGM conditions → BGM; else IDLE.
    - GAP_MS=0: the gap lasts until the next i_tick.
- Timing and width rules:
  - A tick in the same cycle as entry into SFX/GAP does not decrement the freshly loaded timer.
  - Timer is 16 bits. SFX_MS and GAP_MS must be below 65536.
  - o_busy = (state==SFX or state==GAP).
- Reset mid-note: sound stops on the edge after rst==0 is sampled, and all pending requests are dropped.

Test Plan:
- Single request:
  - Stimulus: reset, then i_req=01 with pitch 1000 at cycle 10; i_tick every 10 cycles; SFX_MS=3, GAP_MS=1.
  - Required: o_play_en=1 and o_cnt_limit=1000 from cycle 12; o_grant=01; play ends after the 4th subsequent tick; 1 tick of gap; then IDLE.
- Simultaneous requests:
  - Stimulus: i_req=11 with pitches 1000 and 2000.
  - Required: track 1 plays first (rr reset value), then the gap, then track 2 with o_grant=10. A second 11 pulse is then served track 2 first? No — the pointer has moved past track 2, so track 1 is served first again.
- Overwrite:
  - Stimulus: while track 1 is in SFX, track 2 requests pitch 500, then pitch 700.
  - Required: o_overwrite pulses once; track 2 later plays 700.
- BGM preemption:
  - Stimulus: i_bgm_en=1 with pitch 3000 (state BGM), then i_req=10 with pitch 800.
  - Required: GAP (play_en=0) for GAP_MS ticks, then SFX at 800; after SFX and the gap, return to BGM at the current bgm pitch.
- Zero pitch and reset:
  - Stimulus: i_req=01 with pitch 0.
  - Required: no state change.
  - Stimulus: rst=0 during SFX.
  - Required: next edge all outputs 0, pend=00, IDLE. With rst=0 held, i_req is ignored.

Source files
------------

// File: rtl/tone_arbiter_if.sv
// Signal bundle between the hit/judgement logic, the BGM source and the tone arbiter.
// The arbiter takes the slave modport; the upstream side takes the master modport.
interface tone_arbiter_if #(
  parameter int PW = 32
);
  logic          i_tick;
  logic [1:0]    i_req;
  logic [PW-1:0] i_pitch_t1;
  logic [PW-1:0] i_pitch_t2;
  logic          i_bgm_en;
  logic [PW-1:0] i_bgm_pitch;
  logic          o_play_en;
  logic [PW-1:0] o_cnt_limit;
  logic [1:0]    o_grant;
  logic          o_busy;
  logic          o_overwrite;

  modport master (
    output i_tick, i_req, i_pitch_t1, i_pitch_t2, i_bgm_en, i_bgm_pitch,
    input  o_play_en, o_cnt_limit, o_grant, o_busy, o_overwrite
  );

  modport slave (
    input  i_tick, i_req, i_pitch_t1, i_pitch_t2, i_bgm_en, i_bgm_pitch,
    output o_play_en, o_cnt_limit, o_grant, o_busy, o_overwrite
  );
endinterface

// File: rtl/tone_arbiter.sv
// Shares one piezo tone generator between two latched hit-sound requesters and BGM.
// Hit sounds are served round-robin, timed on the 1 ms tick, and followed by a silent gap.
module tone_arbiter #(
  parameter int unsigned SFX_MS = 100,
  parameter int unsigned GAP_MS = 5,
  parameter int          PW     = 32
) (
  input logic           clk,
  input logic           rst,
  tone_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BGM, SFX, GAP} state_t;

  localparam logic [15:0] SFX_T = 16'(SFX_MS);
  localparam logic [15:0] GAP_T = 16'(GAP_MS);

  state_t        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [1:0]    pend_q, pend_d;
  logic [PW-1:0] pitch_q [2];
  logic [PW-1:0] pitch_d [2];
  logic          rr_q, rr_d;
  logic          play_en_q, play_en_d;
  logic [PW-1:0] cnt_limit_q, cnt_limit_d;
  logic [1:0]    grant_q, grant_d;
  logic          overwrite_q, overwrite_d;

  logic [PW-1:0] pitch_in [2];
  logic [1:0]    req_ok;
  logic          has_pend;
  logic          bgm_ok;
  logic          sel;
  logic          do_grant, do_bgm, do_gap, do_idle;

  assign pitch_in[0] = bus.i_pitch_t1;
  assign pitch_in[1] = bus.i_pitch_t2;
  assign req_ok[0]   = bus.i_req[0] && (bus.i_pitch_t1 != '0);
  assign req_ok[1]   = bus.i_req[1] && (bus.i_pitch_t2 != '0);
  assign has_pend    = |pend_q;
  assign bgm_ok      = bus.i_bgm_en && (bus.i_bgm_pitch != '0);
  // With both tracks pending the pointer decides; otherwise the lone pending track wins.
  assign sel         = (pend_q == 2'b11) ? rr_q : pend_q[1];

  // NOTE: every variable gets its hold/default value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pend_d      = pend_q;
    pitch_d     = pitch_q;
    rr_d        = rr_q;
    play_en_d   = play_en_q;
    cnt_limit_d = cnt_limit_q;
    grant_d     = grant_q;
    overwrite_d = 1'b0;
    do_grant    = 1'b0;
    do_bgm      = 1'b0;
    do_gap      = 1'b0;
    do_idle     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (has_pend)    do_grant = 1'b1;
        else if (bgm_ok) do_bgm   = 1'b1;
        else             do_idle  = 1'b1;
      end
      BGM: begin
        if (has_pend)     do_gap      = 1'b1;
        else if (!bgm_ok) do_idle     = 1'b1;
        else              cnt_limit_d = bus.i_bgm_pitch;
      end
      SFX: begin
        if (bus.i_tick) begin
          if (timer_q == '0) do_gap  = 1'b1;
          else               timer_d = timer_q - 16'd1;
        end
      end
      GAP: begin
        if (bus.i_tick) begin
          if (timer_q != '0)  timer_d  = timer_q - 16'd1;
          else if (has_pend)  do_grant = 1'b1;
          else if (bgm_ok)    do_bgm   = 1'b1;
          else                do_idle  = 1'b1;
        end
      end
      default: do_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_d      = SFX;
      timer_d      = SFX_T;
      pend_d[sel]  = 1'b0;
      rr_d         = ~sel;
      play_en_d    = 1'b1;
      cnt_limit_d  = pitch_q[sel];
      grant_d      = sel ? 2'b10 : 2'b01;
    end
    if (do_bgm) begin
      state_d     = BGM;
      play_en_d   = 1'b1;
      cnt_limit_d = bus.i_bgm_pitch;
      grant_d     = 2'b00;
    end
    // Entering the gap keeps the last limit so the generator word does not glitch.
    if (do_gap) begin
      state_d   = GAP;
      timer_d   = GAP_T;
      play_en_d = 1'b0;
      grant_d   = 2'b00;
    end
    if (do_idle) begin
      state_d     = IDLE;
      play_en_d   = 1'b0;
      cnt_limit_d = '0;
      grant_d     = 2'b00;
    end

    // Capture runs last so a fresh request beats the grant clearing the same pend bit.
    for (int k = 0; k < 2; k++) begin
      if (req_ok[k]) begin
        pend_d[k]  = 1'b1;
        pitch_d[k] = pitch_in[k];
        if (pend_q[k]) overwrite_d = 1'b1;
      end
    end
  end

  // NOTE: the stored pitches are reset too, so a stale pitch can never be granted after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      pend_q      <= '0;
      pitch_q[0]  <= '0;
      pitch_q[1]  <= '0;
      rr_q        <= 1'b0;
      play_en_q   <= 1'b0;
      cnt_limit_q <= '0;
      grant_q     <= '0;
      overwrite_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      pitch_q     <= pitch_d;
      rr_q        <= rr_d;
      play_en_q   <= play_en_d;
      cnt_limit_q <= cnt_limit_d;
      grant_q     <= grant_d;
      overwrite_q <= overwrite_d;
    end
  end

  assign bus.o_play_en   = play_en_q;
  assign bus.o_cnt_limit = cnt_limit_q;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = (state_q == SFX) || (state_q == GAP);
  assign bus.o_overwrite = overwrite_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter: a hand-derived vector table, directed multi-cycle sequences,
// and randomized traffic compared every cycle against a phase/tick-count reference model.
module tb_tone_arbiter;
  localparam int PW  = 16;
  localparam int SFX = 3;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tone_arbiter_if #(.PW(PW)) bus ();

  tone_arbiter #(.SFX_MS(SFX), .GAP_MS(GAP), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          r;
    logic          tick;
    logic [1:0]    req;
    logic [PW-1:0] p1;
    logic [PW-1:0] p2;
    logic          bgm;
    logic [PW-1:0] bp;
  } in_t;

  typedef struct {
    logic          play;
    logic [PW-1:0] limit;
    logic [1:0]    grant;
    logic          busy;
    logic          ow;
  } out_t;

  typedef struct {
    in_t  x;
    out_t e;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases plus a count of ticks seen in the current phase.
  typedef enum {SILENT, MUSIC, NOTE, PAUSE} phase_e;
  phase_e        m_phase;
  logic [1:0]    m_pend;
  logic [PW-1:0] m_stored [2];
  int            m_next;
  int            m_ticks;
  out_t          m_out;

  task automatic m_silent();
    m_phase = SILENT; m_out.play = 1'b0; m_out.limit = '0; m_out.grant = 2'b00;
  endtask

  task automatic m_music(input in_t x);
    m_phase = MUSIC; m_out.play = 1'b1; m_out.limit = x.bp; m_out.grant = 2'b00;
  endtask

  task automatic m_note(input logic [1:0] was);
    int t;
    t = (was == 2'b11) ? m_next : (was[1] ? 1 : 0);
    m_pend[t]   = 1'b0;
    m_next      = 1 - t;
    m_phase     = NOTE;
    m_ticks     = 0;
    m_out.play  = 1'b1;
    m_out.limit = m_stored[t];
    m_out.grant = (t == 1) ? 2'b10 : 2'b01;
  endtask

  task automatic m_pause();
    m_phase = PAUSE; m_ticks = 0; m_out.play = 1'b0; m_out.grant = 2'b00;
  endtask

  task automatic model_step(input in_t x);
    logic [1:0] was;
    logic [PW-1:0] pin;
    logic bgm_ok;
    if (!x.r) begin
      m_pend = 2'b00; m_stored[0] = '0; m_stored[1] = '0; m_next = 0; m_ticks = 0;
      m_silent(); m_out.busy = 1'b0; m_out.ow = 1'b0;
      return;
    end
    was    = m_pend;
    bgm_ok = x.bgm && (x.bp != '0);
    m_out.ow = 1'b0;
    case (m_phase)
      SILENT: if (was != 0) m_note(was); else if (bgm_ok) m_music(x); else m_silent();
      MUSIC:  if (was != 0) m_pause(); else if (!bgm_ok) m_silent(); else m_out.limit = x.bp;
      NOTE: if (x.tick) begin
        m_ticks++;
        if (m_ticks > SFX) m_pause();
      end
      PAUSE: if (x.tick) begin
        m_ticks++;
        if (m_ticks > GAP) begin
          if (was != 0) m_note(was); else if (bgm_ok) m_music(x); else m_silent();
        end
      end
      default: m_silent();
    endcase
    for (int k = 0; k < 2; k++) begin
      pin = (k == 0) ? x.p1 : x.p2;
      if (x.req[k] && pin != '0) begin
        if (was[k]) m_out.ow = 1'b1;
        m_pend[k]   = 1'b1;
        m_stored[k] = pin;
      end
    end
    m_out.busy = (m_phase == NOTE) || (m_phase == PAUSE);
  endtask

  in_t cur;

  task automatic cycle(input in_t x);
    rst             = x.r;
    bus.i_tick      = x.tick;
    bus.i_req       = x.req;
    bus.i_pitch_t1  = x.p1;
    bus.i_pitch_t2  = x.p2;
    bus.i_bgm_en    = x.bgm;
    bus.i_bgm_pitch = x.bp;
    @(posedge clk);
    model_step(x);
    #1;
  endtask

  task automatic compare_out(input string tag, input out_t e);
    check({tag, ".play_en"},   64'(bus.o_play_en),   64'(e.play));
    check({tag, ".cnt_limit"}, 64'(bus.o_cnt_limit), 64'(e.limit));
    check({tag, ".grant"},     64'(bus.o_grant),     64'(e.grant));
    check({tag, ".busy"},      64'(bus.o_busy),      64'(e.busy));
    check({tag, ".overwrite"}, 64'(bus.o_overwrite), 64'(e.ow));
  endtask

  logic [1:0] order [$];
  logic [1:0] prev_grant;

  // Runs n cycles with a tick every 'period' cycles, comparing against the model
  // and logging each new hit-sound owner.
  task automatic run(input int n, input int period, input string tag);
    for (int i = 0; i < n; i++) begin
      cur.tick = ((i % period) == period - 1);
      cycle(cur);
      compare_out(tag, m_out);
      if (bus.o_grant != 2'b00 && bus.o_grant != prev_grant) order.push_back(bus.o_grant);
      prev_grant = bus.o_grant;
      cur.req = 2'b00;
    end
  endtask

  function automatic vec_t v(input logic r, input logic tk, input logic [1:0] rq,
                             input int p1, input int p2, input logic pl, input int lim,
                             input logic [1:0] g, input logic b, input logic ow);
    vec_t t;
    t.x = '{r: r, tick: tk, req: rq, p1: PW'(p1), p2: PW'(p2), bgm: 1'b0, bp: '0};
    t.e = '{play: pl, limit: PW'(lim), grant: g, busy: b, ow: ow};
    return t;
  endfunction

  vec_t tbl [15];
  bit   found;

  initial begin
    // rst tick req p1 p2 | play limit grant busy ow
    tbl[0]  = v(0, 0, 2'b00, 0,    0,   0, 0,    2'b00, 0, 0); // reset state
    tbl[1]  = v(1, 0, 2'b01, 0,    0,   0, 0,    2'b00, 0, 0); // zero pitch ignored
    tbl[2]  = v(1, 0, 2'b01, 1000, 0,   0, 0,    2'b00, 0, 0); // captured only
    tbl[3]  = v(1, 0, 2'b00, 0,    0,   1, 1000, 2'b01, 1, 0); // granted
    tbl[4]  = v(1, 1, 2'b00, 0,    0,   1, 1000, 2'b01, 1, 0);
    tbl[5]  = v(1, 0, 2'b10, 0,    500, 1, 1000, 2'b01, 1, 0); // queued behind SFX
    tbl[6]  = v(1, 0, 2'b10, 0,    700, 1, 1000, 2'b01, 1, 1); // overwrite pulse
    tbl[7]  = v(1, 1, 2'b00, 0,    0,   1, 1000, 2'b01, 1, 0);
    tbl[8]  = v(1, 1, 2'b00, 0,    0,   1, 1000, 2'b01, 1, 0);
    tbl[9]  = v(1, 1, 2'b00, 0,    0,   0, 1000, 2'b00, 1, 0); // 4th tick: gap
    tbl[10] = v(1, 1, 2'b00, 0,    0,   0, 1000, 2'b00, 1, 0);
    tbl[11] = v(1, 1, 2'b00, 0,    0,   1, 700,  2'b10, 1, 0); // track 2 plays 700
    tbl[12] = v(0, 0, 2'b00, 0,    0,   0, 0,    2'b00, 0, 0); // reset mid-note
    tbl[13] = v(0, 0, 2'b01, 1234, 0,   0, 0,    2'b00, 0, 0); // request held off in reset
    tbl[14] = v(1, 0, 2'b00, 0,    0,   0, 0,    2'b00, 0, 0); // nothing left pending

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].x);
      compare_out($sformatf("vec%0d", i), tbl[i].e);
    end

    // Simultaneous requests: track 1, track 2, then track 1 again on a second 11 pulse.
    cur = '{r: 1'b1, tick: 1'b0, req: 2'b11, p1: PW'(1000), p2: PW'(2000), bgm: 1'b0, bp: '0};
    prev_grant = 2'b00;
    run(80, 4, "dual1");
    cur.req = 2'b11;
    run(80, 4, "dual2");
    check("dual.count", 64'(order.size()), 64'd4);
    if (order.size() >= 4) begin
      check("dual.first",  64'(order[0]), 64'(2'b01));
      check("dual.second", 64'(order[1]), 64'(2'b10));
      check("dual.third",  64'(order[2]), 64'(2'b01));
      check("dual.fourth", 64'(order[3]), 64'(2'b10));
    end

    // BGM preemption, then return to BGM at its current pitch.
    cur.bgm = 1'b1; cur.bp = PW'(3000);
    run(5, 100, "bgm");
    check("bgm.play",  64'(bus.o_play_en),   64'd1);
    check("bgm.limit", 64'(bus.o_cnt_limit), 64'd3000);
    check("bgm.grant", 64'(bus.o_grant),     64'd0);
    cur.req = 2'b10; cur.p2 = PW'(800);
    run(2, 100, "pre");
    check("pre.gap_play", 64'(bus.o_play_en), 64'd0);
    check("pre.gap_busy", 64'(bus.o_busy),    64'd1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      run(1, 1, "pre_wait");
      found = (bus.o_grant == 2'b10);
    end
    check("pre.sfx_reached", 64'(found), 64'd1);
    check("pre.sfx_limit", 64'(bus.o_cnt_limit), 64'd800);
    cur.bp = PW'(3100);
    run(60, 4, "ret");
    check("ret.play",  64'(bus.o_play_en),   64'd1);
    check("ret.grant", 64'(bus.o_grant),     64'd0);
    check("ret.busy",  64'(bus.o_busy),      64'd0);
    check("ret.limit", 64'(bus.o_cnt_limit), 64'd3100);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cur.r    = ($urandom_range(0, 399) != 0);
      cur.tick = ($urandom_range(0, 3) == 0);
      cur.req  = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      cur.p1   = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom);
      cur.p2   = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom);
      if ($urandom_range(0, 49) == 0) cur.bgm = ~cur.bgm;
      if ($urandom_range(0, 29) == 0) cur.bp = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom);
      cycle(cur);
      compare_out("rand", m_out);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
